// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word loads with extension, read-modify-write sub-word stores.
// Optional build macro LSU_MISALIGN_TRAP_EN rejects misaligned H/HU/W accesses instead of performing them.
module load_store_unit #(
    parameter int unsigned ADDR_LIMIT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [32:0] LIMIT = 33'(ADDR_LIMIT);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t      state;
    state_t      next_state;

    logic        we_q;
    logic        err_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_err;
    logic        next_read;
    logic        next_write;
    logic [31:0] next_addr;
    logic [31:0] next_wdata;

    function automatic logic [32:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   access_size = 33'd1;
            2'b01:   access_size = 33'd2;
            default: access_size = 33'd4;
        endcase
    endfunction

    // Range check is done in 33 bits so an address near 2^32 cannot wrap into range.
    function automatic logic access_error(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr);
        logic bad_code;
        logic out_of_range;
        logic misaligned;
        bad_code     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
        out_of_range = ({1'b0, addr} + access_size(f3)) > LIMIT;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                       ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misaligned   = 1'b0;
`endif
        access_error = bad_code || out_of_range || misaligned;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] f3);
        case (f3)
            3'b000:  extend_load = {{24{word[7]}}, word[7:0]};
            3'b001:  extend_load = {{16{word[15]}}, word[15:0]};
            3'b100:  extend_load = {24'd0, word[7:0]};
            3'b101:  extend_load = {16'd0, word[15:0]};
            default: extend_load = word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] data, input logic [2:0] f3);
        case (f3)
            3'b000:  merge_store = {old_word[31:8], data[7:0]};
            3'b001:  merge_store = {old_word[31:16], data[15:0]};
            default: merge_store = data;
        endcase
    endfunction

    assign accept  = req_valid && (state == IDLE);
    assign req_err = access_error(req_we, req_funct3, req_addr);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        next_state = RESP;
                    else if (req_we && (req_funct3 == 3'b010))
                        next_state = WR;
                    else
                        next_state = RD;
                end
            end
            RD:      next_state = CAP;
            CAP:     next_state = we_q ? WR : RESP;
            WR:      next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory strobes are registered from the upcoming state; sub-word merges use the word read in CAP.
    always_comb begin
        next_read  = (next_state == RD);
        next_write = (next_state == WR);
        next_addr  = 32'd0;
        next_wdata = 32'd0;
        if (next_read || next_write)
            next_addr = (state == IDLE) ? req_addr : addr_q;
        if (next_write)
            next_wdata = (state == IDLE) ? req_wdata : merge_store(mem_rdata, wdata_q, funct3_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            state     <= next_state;
            mem_read  <= next_read;
            mem_write <= next_write;
            mem_addr  <= next_addr;
            mem_wdata <= next_wdata;
            if (accept) begin
                we_q  <= req_we;
                err_q <= req_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
        if (state == CAP)
            rdata_q <= mem_rdata;
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? extend_load(rdata_q, funct3_q) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses against a byte-array reference model.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int unsigned LIMIT = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem     [0:511];
    logic [7:0] ref_mem [0:511];
    logic       mem_init;

    load_store_unit #(.ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    // Byte-addressed little-endian data memory: read word appears the cycle after mem_read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_byte(i);
        end else begin
            if (mem_read)
                mem_rdata <= {mem[(int'(mem_addr[8:0]) + 3) & 511], mem[(int'(mem_addr[8:0]) + 2) & 511],
                              mem[(int'(mem_addr[8:0]) + 1) & 511], mem[int'(mem_addr[8:0])]};
            if (mem_write)
                for (int i = 0; i < 4; i++)
                    mem[(int'(mem_addr[8:0]) + i) & 511] <= 8'(mem_wdata >> (8 * i));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        longint val;
        int     size;
        val  = 0;
        size = 1 << int'(f3[1:0]);
        for (int i = size - 1; i >= 0; i--)
            val = val * 256 + longint'(ref_mem[(int'(addr) + i) & 511]);
        if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
            val = val - (longint'(1) << (8 * size));
        return val[31:0];
    endfunction

    function automatic logic [31:0] model_store_word(input logic [2:0] f3, input logic [31:0] addr,
                                                     input logic [31:0] wd);
        longint old;
        longint m;
        int     size;
        old  = 0;
        size = 1 << int'(f3[1:0]);
        for (int i = 3; i >= 0; i--)
            old = old * 256 + longint'(ref_mem[(int'(addr) + i) & 511]);
        if (size == 4) return wd;
        m = longint'(1) << (8 * size);
        return 32'((old - (old % m)) + (longint'(wd) % m));
    endfunction

    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] got_data, output logic got_err);
        int          size, exp_lat, lat, resp_cnt, rd_cnt, wr_cnt, wr_cyc, busy_ready, both, wait_cyc;
        logic        exp_err, ready_after, exp_rd, exp_wr;
        logic [31:0] exp_data, exp_wword, wr_word, wr_addr, rd_addr;
        size    = 1 << int'(f3[1:0]);
        exp_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) ||
                  ((longint'(addr) + longint'(size)) > longint'(LIMIT));
`ifdef LSU_MISALIGN_TRAP_EN
        if (((size == 2) && (addr % 2 != 0)) || ((size == 4) && (addr % 4 != 0))) exp_err = 1'b1;
`endif
        exp_data  = (!we && !exp_err) ? model_load(f3, addr) : 32'd0;
        exp_wword = (we && !exp_err) ? model_store_word(f3, addr, wd) : 32'd0;
        exp_lat   = exp_err ? 1 : (!we ? 3 : ((size == 4) ? 2 : 4));
        exp_wr    = we && !exp_err;
        exp_rd    = !exp_err && !(we && size == 4);
        lat = 0; resp_cnt = 0; rd_cnt = 0; wr_cnt = 0; wr_cyc = 0; busy_ready = 0; both = 0;
        ready_after = 1'b0; got_data = 32'd0; got_err = 1'b0;
        wr_word = 32'd0; wr_addr = 32'd0; rd_addr = 32'd0;

        @(negedge clk);
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("ready_before", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (mem_read) begin
                rd_cnt++;
                rd_addr = mem_addr;
            end
            if (mem_write) begin
                wr_cnt++;
                wr_cyc  = k;
                wr_word = mem_wdata;
                wr_addr = mem_addr;
            end
            if (mem_read && mem_write) both++;
            if (resp_valid) begin
                resp_cnt++;
                if (lat == 0) begin
                    lat      = k;
                    got_data = resp_rdata;
                    got_err  = resp_err;
                end
            end
            if (lat == 0 && req_ready) busy_ready++;
            if (lat != 0 && k == lat + 1) ready_after = req_ready;
        end

        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_count", 32'(resp_cnt), 32'd1);
        check("resp_err", 32'(got_err), 32'(exp_err));
        check("resp_rdata", got_data, exp_data);
        check("read_strobes", 32'(rd_cnt), 32'(exp_rd));
        check("write_strobes", 32'(wr_cnt), 32'(exp_wr));
        check("ready_while_busy", 32'(busy_ready), 32'd0);
        check("read_write_overlap", 32'(both), 32'd0);
        check("ready_after_resp", 32'(ready_after), 32'd1);
        if (exp_rd) check("read_addr", rd_addr, addr);
        if (exp_wr) begin
            check("write_cycle", 32'(wr_cyc), (size == 4) ? 32'd1 : 32'd3);
            check("write_word", wr_word, exp_wword);
            check("write_addr", wr_addr, addr);
            for (int i = 0; i < size; i++)
                ref_mem[(int'(addr) + i) & 511] = 8'(wd >> (8 * i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          cnt;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rwd;
        logic [2:0]  codes [0:4];

        codes[0] = 3'd0; codes[1] = 3'd1; codes[2] = 3'd2; codes[3] = 3'd4; codes[4] = 3'd5;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_init = 1'b1;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(i);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        rst_n    = 1'b1;

        // Word store then load back.
        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e);
        access(1'b0, 3'b010, 32'h10, 32'd0, d, e);
        check("lw_deadbeef", d, 32'hDEADBEEF);
        check("lw_deadbeef_err", 32'(e), 32'd0);

        // Byte store merge and signed/unsigned byte loads.
        access(1'b1, 3'b010, 32'h20, 32'h11223344, d, e);
        access(1'b1, 3'b000, 32'h20, 32'h000000AA, d, e);
        access(1'b0, 3'b010, 32'h20, 32'd0, d, e);
        check("sb_merged_word", d, 32'h112233AA);
        access(1'b0, 3'b000, 32'h20, 32'd0, d, e);
        check("lb_aa", d, 32'hFFFFFFAA);
        access(1'b0, 3'b100, 32'h20, 32'd0, d, e);
        check("lbu_aa", d, 32'h000000AA);

        // Half-word extension.
        access(1'b1, 3'b010, 32'h20, 32'h80007FFF, d, e);
        access(1'b0, 3'b001, 32'h20, 32'd0, d, e);
        check("lh_7fff", d, 32'h00007FFF);
        access(1'b0, 3'b001, 32'h22, 32'd0, d, e);
        check("lh_8000", d, 32'hFFFF8000);
        access(1'b0, 3'b101, 32'h22, 32'd0, d, e);
        check("lhu_8000", d, 32'h00008000);
        access(1'b1, 3'b001, 32'h40, 32'h1234BEEF, d, e);
        access(1'b0, 3'b010, 32'h40, 32'd0, d, e);
        check("sh_low_half", d[15:0], 32'h0000BEEF);

        // Range boundary and illegal codes.
        access(1'b0, 3'b010, 32'hFD, 32'd0, d, e);
        check("lw_fd_err", 32'(e), 32'd1);
        access(1'b0, 3'b000, 32'hFF, 32'd0, d, e);
        check("lb_ff_err", 32'(e), 32'd0);
        access(1'b1, 3'b001, 32'hFF, 32'h5555, d, e);
        check("sh_ff_err", 32'(e), 32'd1);
        access(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, d, e);
        check("lw_wrap_err", 32'(e), 32'd1);
        access(1'b0, 3'b011, 32'h20, 32'd0, d, e);
        check("f3_011_err", 32'(e), 32'd1);
        access(1'b1, 3'b100, 32'h20, 32'h77, d, e);
        check("store_bu_err", 32'(e), 32'd1);

        // Misaligned word load.
        access(1'b1, 3'b010, 32'h24, 32'h000000C3, d, e);
        access(1'b0, 3'b010, 32'h21, 32'd0, d, e);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_21_err", 32'(e), 32'd1);
`else
        check("lw_21_err", 32'(e), 32'd0);
        check("lw_21_data", d, 32'hC380007F);
`endif

        // Reset while a byte store sits in CAP.
        access(1'b1, 3'b010, 32'h30, 32'h55667788, d, e);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h30; req_wdata = 32'h11;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_rd_strobe", 32'(mem_read), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_mem_read", 32'(mem_read), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_write || resp_valid) cnt++;
        end
        check("abort_no_late_activity", 32'(cnt), 32'd0);
        access(1'b0, 3'b010, 32'h30, 32'd0, d, e);
        check("abort_mem_unchanged", d, 32'h55667788);

        // Randomized accesses against the reference model.
        for (int n = 0; n < 150; n++) begin
            rwe = 1'($urandom);
            rf3 = ($urandom_range(0, 9) < 8) ? codes[$urandom_range(0, 4)] : 3'($urandom);
            if ($urandom_range(0, 3) == 0)
                ra = $urandom_range(LIMIT - 6, LIMIT + 2);
            else
                ra = $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1)
                ra = ra & ~((32'd1 << rf3[1:0]) - 32'd1);
            rwd = $urandom;
            access(rwe, rf3, ra, rwd, d, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
